// File: rtl/odd_issue_ctrl.sv
// SPU odd-pipe issue scheduler: valid/ready intake, writeback-slot scoreboard, drain FSM.
// Optional ODD_ISSUE_STATS_EN adds stall_cycles / issue_count counters.
module odd_issue_ctrl #(
  parameter int PERM_LAT = 4,
  parameter int LS_LAT   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_unit,
  input  logic [0:6] in_rt_addr,
  input  logic [0:6] in_ra_addr,
  input  logic [0:6] in_rb_addr,
  input  logic       in_uses_ra,
  input  logic       in_uses_rb,
  input  logic       in_reg_write,
  input  logic       flush,
  output logic       perm_issue,
  output logic       ls_issue,
  output logic [0:6] issue_rt_addr,
  output logic       issue_reg_write,
  output logic       sb_empty
`ifdef ODD_ISSUE_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] issue_count
`endif
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state, next_state;
  logic [LS_LAT:0] sb_valid;
  logic [0:6]      sb_rt [0:LS_LAT];
  logic            raw_hit, waw_hit, slot_busy, hazard, accept;

  assign sb_empty = ~|sb_valid;
  assign accept   = in_valid & in_ready;

  // Slot k holds the destination written back k cycles from now; no bypass, so slot 0 still blocks.
  always_comb begin
    raw_hit   = 1'b0;
    waw_hit   = 1'b0;
    slot_busy = 1'b0;
    for (int k = 0; k <= LS_LAT; k++) begin
      if (sb_valid[k]) begin
        if (in_uses_ra && (sb_rt[k] == in_ra_addr)) raw_hit = 1'b1;
        if (in_uses_rb && (sb_rt[k] == in_rb_addr)) raw_hit = 1'b1;
        if (sb_rt[k] == in_rt_addr)                 waw_hit = 1'b1;
      end
      if (!in_unit && (k == PERM_LAT + 1)) slot_busy = sb_valid[k];
    end
    hazard = raw_hit | (in_reg_write & (waw_hit | slot_busy));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (flush)    next_state = DRAIN;
      DRAIN:   if (sb_empty) next_state = RUN;
      default:               next_state = RUN;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN) & ~flush & ~hazard;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_valid <= '0;
      for (int k = 0; k <= LS_LAT; k++) sb_rt[k] <= '0;
    end else begin
      for (int k = 0; k < LS_LAT; k++) begin
        sb_valid[k] <= sb_valid[k+1];
        sb_rt[k]    <= sb_rt[k+1];
      end
      sb_valid[LS_LAT] <= 1'b0;
      sb_rt[LS_LAT]    <= '0;
      if (accept && in_reg_write) begin
        if (in_unit) begin
          sb_valid[LS_LAT] <= 1'b1;
          sb_rt[LS_LAT]    <= in_rt_addr;
        end else begin
          sb_valid[PERM_LAT] <= 1'b1;
          sb_rt[PERM_LAT]    <= in_rt_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perm_issue      <= 1'b0;
      ls_issue        <= 1'b0;
      issue_rt_addr   <= '0;
      issue_reg_write <= 1'b0;
    end else begin
      perm_issue <= accept & ~in_unit;
      ls_issue   <= accept & in_unit;
      if (accept) begin
        issue_rt_addr   <= in_rt_addr;
        issue_reg_write <= in_reg_write;
      end
    end
  end

`ifdef ODD_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      if (in_valid && !in_ready) stall_cycles <= stall_cycles + 32'd1;
      if (accept)                issue_count  <= issue_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_odd_issue_ctrl.sv
// Randomized + directed bench for odd_issue_ctrl against a writeback-time reference model.
module tb_odd_issue_ctrl;

  localparam int PERM_LAT = 4;
  localparam int LS_LAT   = 6;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, in_unit;
  logic [0:6] in_rt_addr, in_ra_addr, in_rb_addr;
  logic       in_uses_ra, in_uses_rb, in_reg_write, flush;
  logic       perm_issue, ls_issue, issue_reg_write, sb_empty;
  logic [0:6] issue_rt_addr;
`ifdef ODD_ISSUE_STATS_EN
  logic [31:0] stall_cycles, issue_count;
`endif

  odd_issue_ctrl #(.PERM_LAT(PERM_LAT), .LS_LAT(LS_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit),
    .in_rt_addr(in_rt_addr), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
    .in_uses_ra(in_uses_ra), .in_uses_rb(in_uses_rb), .in_reg_write(in_reg_write),
    .flush(flush), .perm_issue(perm_issue), .ls_issue(ls_issue),
    .issue_rt_addr(issue_rt_addr), .issue_reg_write(issue_reg_write), .sb_empty(sb_empty)
`ifdef ODD_ISSUE_STATS_EN
    , .stall_cycles(stall_cycles), .issue_count(issue_count)
`endif
  );

  always #5 clk = ~clk;

  // Model: each pending write is just its register and the absolute cycle of its writeback.
  typedef struct { logic [0:6] rt; int wb; } wb_t;
  wb_t         pending[$];
  int          cyc = 0, total = 0, bad = 0;
  bit          model_known = 0, draining = 0;
  logic        exp_perm = 0, exp_ls = 0, exp_rw = 0;
  logic [0:6]  exp_rt = '0;
  int unsigned exp_stall = 0, exp_issue = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input bit unit, input logic [0:6] rt,
                               input logic [0:6] ra, input logic [0:6] rb, input bit ura,
                               input bit urb, input bit rw, input bit fl, output bit acc);
    wb_t keep[$];
    wb_t ent;
    bit  empty, haz, ready;
    int  lat;
    @(negedge clk);
    reset = rst; in_valid = v; in_unit = unit; in_rt_addr = rt; in_ra_addr = ra;
    in_rb_addr = rb; in_uses_ra = ura; in_uses_rb = urb; in_reg_write = rw; flush = fl;
    #1;
    foreach (pending[i]) if (pending[i].wb >= cyc) keep.push_back(pending[i]);
    pending = keep;
    empty = (pending.size() == 0);
    lat   = unit ? LS_LAT : PERM_LAT;
    haz   = 1'b0;
    foreach (pending[i]) begin
      if (ura && pending[i].rt == ra) haz = 1'b1;
      if (urb && pending[i].rt == rb) haz = 1'b1;
      if (rw && pending[i].rt == rt) haz = 1'b1;
      if (rw && pending[i].wb == cyc + 1 + lat) haz = 1'b1;
    end
    ready = !draining && !fl && !haz;
    if (model_known) begin
      checkOutput("perm_issue", {31'd0, perm_issue}, {31'd0, exp_perm});
      checkOutput("ls_issue", {31'd0, ls_issue}, {31'd0, exp_ls});
      checkOutput("issue_rt_addr", {25'd0, issue_rt_addr}, {25'd0, exp_rt});
      checkOutput("issue_reg_write", {31'd0, issue_reg_write}, {31'd0, exp_rw});
      checkOutput("sb_empty", {31'd0, sb_empty}, {31'd0, empty});
      if (!rst) checkOutput("in_ready", {31'd0, in_ready}, {31'd0, ready});
`ifdef ODD_ISSUE_STATS_EN
      checkOutput("stall_cycles", stall_cycles, exp_stall);
      checkOutput("issue_count", issue_count, exp_issue);
`endif
    end
    acc = v && ready && !rst;
    if (rst) begin
      pending.delete();
      draining = 0; exp_perm = 0; exp_ls = 0; exp_rt = '0; exp_rw = 0;
      exp_stall = 0; exp_issue = 0; model_known = 1;
    end else begin
      exp_perm = acc && !unit;
      exp_ls   = acc && unit;
      if (acc) begin
        exp_rt = rt; exp_rw = rw;
      end
      if (acc && rw) begin
        ent.rt = rt; ent.wb = cyc + 1 + lat;
        pending.push_back(ent);
      end
      if (v && !ready) exp_stall++;
      if (acc) exp_issue++;
      if (!draining && fl) draining = 1;
      else if (draining && empty) draining = 0;
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic offerUntilAccepted(input bit unit, input logic [0:6] rt, input logic [0:6] ra,
                                    input logic [0:6] rb, input bit ura, input bit urb);
    bit acc = 0;
    for (int i = 0; i < 20 && !acc; i++) applyStimulus(0, 1, unit, rt, ra, rb, ura, urb, 1, 0, acc);
    if (!acc) checkOutput("offer_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    bit acc, hold;
    bit v, unit, ura, urb, rw, fl, rst;
    logic [0:6] rt, ra, rb;
    reset = 1; in_valid = 0; in_unit = 0; in_rt_addr = '0; in_ra_addr = '0; in_rb_addr = '0;
    in_uses_ra = 0; in_uses_rb = 0; in_reg_write = 0; flush = 0;

    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 7'd1, 7'd2, 7'd3, 0, 0, 1, 0, acc);
    applyStimulus(0, 1, 0, 7'd1, 7'd2, 7'd3, 0, 0, 1, 0, acc);
    idle(8);

    $display("[TB] back-to-back permute");
    for (int r = 3; r <= 5; r++) applyStimulus(0, 1, 0, 7'(r), 7'd20, 7'd21, 1, 1, 1, 0, acc);
    idle(9);

    $display("[TB] RAW hazard");
    applyStimulus(0, 1, 0, 7'd10, 7'd0, 7'd0, 0, 0, 1, 0, acc);
    offerUntilAccepted(0, 7'd11, 7'd10, 7'd0, 1, 0);
    idle(8);

    $display("[TB] writeback slot collision");
    applyStimulus(0, 1, 1, 7'd20, 7'd0, 7'd0, 0, 0, 1, 0, acc);
    idle(1);
    offerUntilAccepted(0, 7'd30, 7'd0, 7'd0, 0, 0);
    idle(9);

    $display("[TB] WAW hazard");
    applyStimulus(0, 1, 1, 7'd7, 7'd0, 7'd0, 0, 0, 1, 0, acc);
    offerUntilAccepted(0, 7'd7, 7'd0, 7'd0, 0, 0);
    idle(9);

    $display("[TB] flush drain and reset mid-drain");
    applyStimulus(0, 1, 1, 7'd40, 7'd0, 7'd0, 0, 0, 1, 0, acc);
    applyStimulus(0, 1, 1, 7'd41, 7'd0, 7'd0, 0, 0, 1, 0, acc);
    applyStimulus(0, 1, 0, 7'd50, 7'd1, 7'd2, 0, 0, 1, 1, acc);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 7'd50, 7'd1, 7'd2, 0, 0, 1, 0, acc);
    applyStimulus(0, 1, 1, 7'd42, 7'd0, 7'd0, 0, 0, 1, 0, acc);
    applyStimulus(0, 0, 0, 7'd0, 7'd0, 7'd0, 0, 0, 0, 1, acc);
    idle(2);
    applyStimulus(1, 0, 0, 7'd0, 7'd0, 7'd0, 0, 0, 0, 0, acc);
    applyStimulus(0, 1, 0, 7'd42, 7'd0, 7'd0, 0, 0, 1, 0, acc);
    idle(8);

    $display("[TB] random traffic");
    hold = 0; acc = 0;
    v = 0; unit = 0; ura = 0; urb = 0; rw = 0; rt = '0; ra = '0; rb = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!(hold && $urandom_range(0, 7) != 0)) begin
        v    = ($urandom_range(0, 3) != 0);
        unit = $urandom_range(0, 1) == 1;
        rt   = 7'($urandom_range(0, 7));
        ra   = 7'($urandom_range(0, 7));
        rb   = 7'($urandom_range(0, 7));
        ura  = $urandom_range(0, 1) == 1;
        urb  = $urandom_range(0, 1) == 1;
        rw   = ($urandom_range(0, 4) != 0);
      end
      fl  = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(rst, v, unit, rt, ra, rb, ura, urb, rw, fl, acc);
      hold = v && !acc;
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
